fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory request at a time, buffers
// returned words in a 2-entry FIFO toward the decoder, halts on an all-zero
// word and handles branch redirects by flushing and dropping the stale reply.
module fetch_sequencer #(
  parameter int ADDR_WIDTH         = 64,
  parameter int INSTRUCTION_LENGTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         entry_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] mem_resp_data,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INSTRUCTION_LENGTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0]         inst_pc,
  output logic                          busy,
  output logic                          halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [ADDR_WIDTH-1:0]         r_pc;
  logic [ADDR_WIDTH-1:0]         r_out_pc;
  logic                          r_drop;
  logic [INSTRUCTION_LENGTH-1:0] r_fifo_data [2];
  logic [ADDR_WIDTH-1:0]         r_fifo_pc   [2];
  logic                          r_rd_ptr;
  logic                          r_wr_ptr;
  logic [1:0]                    r_count;

  logic w_req_valid;
  logic w_req_fire;
  logic w_redirect;
  logic w_resp_wait;
  logic w_zero;
  logic w_push;
  logic w_pop;
  logic w_outstanding_next;

  // A request is only offered when there is guaranteed room for its reply,
  // which is what keeps the 2-entry FIFO from ever overflowing.
  assign w_req_valid = (r_state == S_FETCH) && (r_count < 2'd2) && !r_drop;
  assign w_req_fire  = w_req_valid && mem_req_ready;
  assign w_redirect  = redirect_valid && (r_state != S_IDLE);
  assign w_resp_wait = (r_state == S_WAIT) && mem_resp_valid;
  assign w_zero      = (mem_resp_data == '0);
  assign w_push      = w_resp_wait && !w_zero && !w_redirect;
  assign w_pop       = (r_count != 2'd0) && inst_ready && !w_redirect;
  // Will a reply still be owed to us after this edge? Used to arm the drop
  // flag on a redirect so the stale reply is swallowed later.
  assign w_outstanding_next = ((r_state == S_WAIT) && !mem_resp_valid) ||
                              w_req_fire ||
                              (r_drop && !mem_resp_valid);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; redirect outranks everything except in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FETCH;
      S_FETCH: begin
        if (w_redirect)      w_state_next = S_FETCH;
        else if (w_req_fire) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_redirect)          w_state_next = S_FETCH;
        else if (mem_resp_valid) w_state_next = w_zero ? S_HALT : S_FETCH;
      end
      S_HALT:  if (w_redirect) w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs, forced to zero while reset is held
  always_comb begin
    mem_req_valid = !reset && w_req_valid;
    mem_req_addr  = reset ? '0 : r_pc;
    inst_valid    = !reset && (r_count != 2'd0);
    inst_out      = reset ? '0 : r_fifo_data[r_rd_ptr];
    inst_pc       = reset ? '0 : r_fifo_pc[r_rd_ptr];
    busy          = !reset && ((r_state == S_FETCH) || (r_state == S_WAIT));
    halted        = !reset && (r_state == S_HALT);
  end

  // Program counter, outstanding address, drop flag and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_out_pc <= '0;
      r_drop   <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if ((r_state == S_IDLE) && start) r_pc <= entry_pc;
      else if (w_redirect)              r_pc <= redirect_pc;
      else if (w_req_fire)              r_pc <= r_pc + ADDR_WIDTH'(4);

      if (w_req_fire) r_out_pc <= r_pc;

      if (w_redirect)                    r_drop <= w_outstanding_next;
      else if (r_drop && mem_resp_valid) r_drop <= 1'b0;

      if (w_redirect) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage, one slot per generate iteration
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (reset) begin
        r_fifo_data[gi] <= '0;
        r_fifo_pc[gi]   <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_fifo_data[gi] <= mem_resp_data;
        r_fifo_pc[gi]   <= r_out_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-timed memory and decoder behaviour.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] entry_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        busy;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_WIDTH(64), .INSTRUCTION_LENGTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // advance one clock; sample point is 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; entry_pc = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] pc);
    start = 1'b1; entry_pc = pc;
    cyc();
    start = 1'b0;
  endtask

  // request at exp_addr accepted, one-cycle reply with data
  task automatic do_fetch(input logic [63:0] exp_addr, input logic [31:0] data);
    check_val("req_valid", 64'(mem_req_valid), 64'd1);
    check_val("req_addr", mem_req_addr, exp_addr);
    cyc();
    check_val("wait_req_low", 64'(mem_req_valid), 64'd0);
    check_val("wait_busy", 64'(busy), 64'd1);
    mem_resp_valid = 1'b1; mem_resp_data = data;
    cyc();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  initial begin
    // reset values
    do_reset();
    reset = 1'b1;
    #1;
    check_val("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    cyc();
    check_val("idle_busy", 64'(busy), 64'd0);
    check_val("idle_halted", 64'(halted), 64'd0);
    check_val("idle_inst_valid", 64'(inst_valid), 64'd0);

    // streaming fetch
    do_start(64'h1000);
    check_val("s_busy", 64'(busy), 64'd1);
    do_fetch(64'h1000, 32'hA000_0001);
    check_val("s_iv0", 64'(inst_valid), 64'd1);
    check_val("s_pc0", inst_pc, 64'h1000);
    check_val("s_out0", 64'(inst_out), 64'hA000_0001);
    do_fetch(64'h1004, 32'hA000_0002);
    check_val("s_pc1", inst_pc, 64'h1004);
    check_val("s_out1", 64'(inst_out), 64'hA000_0002);
    do_fetch(64'h1008, 32'hA000_0003);
    check_val("s_pc2", inst_pc, 64'h1008);

    // decoder backpressure fills the FIFO to two entries
    do_reset();
    inst_ready = 1'b0;
    do_start(64'h1000);
    do_fetch(64'h1000, 32'hB000_0001);
    do_fetch(64'h1004, 32'hB000_0002);
    check_val("bp_req_low", 64'(mem_req_valid), 64'd0);
    check_val("bp_head_pc", inst_pc, 64'h1000);
    cyc();
    check_val("bp_req_low2", 64'(mem_req_valid), 64'd0);
    check_val("bp_head_stable", 64'(inst_out), 64'hB000_0001);
    inst_ready = 1'b1;
    cyc();
    check_val("bp_head_pc1", inst_pc, 64'h1004);
    check_val("bp_head_out1", 64'(inst_out), 64'hB000_0002);
    do_fetch(64'h1008, 32'hB000_0003);
    check_val("bp_pc2", inst_pc, 64'h1008);

    // redirect while waiting, stale reply dropped
    do_reset();
    do_start(64'h1000);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    cyc();
    redirect_valid = 1'b0;
    check_val("rd_iv", 64'(inst_valid), 64'd0);
    check_val("rd_req_low", 64'(mem_req_valid), 64'd0);
    cyc();
    check_val("rd_req_low2", 64'(mem_req_valid), 64'd0);
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    cyc();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    check_val("rd_dropped_iv", 64'(inst_valid), 64'd0);
    do_fetch(64'h2000, 32'hC000_0001);
    check_val("rd_iv_new", 64'(inst_valid), 64'd1);
    check_val("rd_pc_new", inst_pc, 64'h2000);
    check_val("rd_out_new", 64'(inst_out), 64'hC000_0001);

    // zero word halts; buffered entry still drains; redirect resumes
    do_reset();
    do_start(64'h1000);
    do_fetch(64'h1000, 32'hD000_0001);
    do_fetch(64'h1004, 32'hD000_0002);
    do_fetch(64'h1008, 32'hD000_0003);
    inst_ready = 1'b0;
    do_fetch(64'h100C, 32'h0000_0000);
    check_val("h_halted", 64'(halted), 64'd1);
    check_val("h_busy", 64'(busy), 64'd0);
    check_val("h_req_low", 64'(mem_req_valid), 64'd0);
    check_val("h_iv", 64'(inst_valid), 64'd1);
    check_val("h_pc", inst_pc, 64'h1008);
    cyc();
    check_val("h_req_low2", 64'(mem_req_valid), 64'd0);
    inst_ready = 1'b1;
    cyc();
    check_val("h_drained", 64'(inst_valid), 64'd0);
    check_val("h_still_halted", 64'(halted), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    cyc();
    redirect_valid = 1'b0;
    check_val("h_resume_halted", 64'(halted), 64'd0);
    check_val("h_resume_busy", 64'(busy), 64'd1);
    check_val("h_resume_req", 64'(mem_req_valid), 64'd1);
    check_val("h_resume_addr", mem_req_addr, 64'h3000);

    // address wrap-around
    do_reset();
    do_start(64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hE000_0001);
    check_val("w_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("w_next_addr", mem_req_addr, 64'h0);

    // reset in WAIT, late reply ignored, redirect ignored in IDLE
    do_reset();
    do_start(64'h1000);
    cyc();
    reset = 1'b1;
    #1;
    check_val("mr_addr0", mem_req_addr, 64'h0);
    check_val("mr_busy0", 64'(busy), 64'd0);
    cyc();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    cyc();
    mem_resp_valid = 1'b0;
    check_val("mr_iv", 64'(inst_valid), 64'd0);
    check_val("mr_busy", 64'(busy), 64'd0);
    check_val("mr_req", 64'(mem_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    cyc();
    redirect_valid = 1'b0;
    check_val("idle_redirect_busy", 64'(busy), 64'd0);
    check_val("idle_redirect_req", 64'(mem_req_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
